alu_operand_stage: RTL
======================

# alu_operand_stage

Registered operand-select stage between register-file read and ALU input. Generalises the ALUSrc operand-B select to a parametrised width and immediate size, adds N-way forwarding on both operands, and registers the result behind a 2-entry valid/ready skid buffer. Downstream stall or flush therefore never drops or duplicates an operand pair.

## Interface
Parameters:
- WIDTH, 8, datapath width of register data, forwarding data and ALU operands
- IMM_WIDTH, 4, raw immediate width, sign-extended to WIDTH; 1 ≤ IMM_WIDTH ≤ WIDTH
- NUM_FWD, 2, number of forwarding sources, ≥ 1; SEL_W = max(1, $clog2(NUM_FWD+1))

Ports:
- clk  input  1  clock; all state updates on the rising edge
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  operand request valid
- in_ready  output  1  stage can accept a request this cycle
- rs_data  input  WIDTH  register-file read data for operand A
- rt_data  input  WIDTH  register-file read data for operand B
- imm  input  IMM_WIDTH  raw immediate
- alu_src  input  1  0 = operand B from register/forwarding path; 1 = operand B from sign-extended immediate
- fwd_sel_a  input  SEL_W  0 = rs_data; k in 1..NUM_FWD = forwarding slice k-1
- fwd_sel_b  input  SEL_W  same encoding, applied to rt_data
- fwd_data  input  NUM_FWD*WIDTH  forwarding sources; slice k occupies bits [k*WIDTH +: WIDTH]
- flush  input  1  discard all held and incoming operands
- out_valid  output  1  op_a/op_b valid
- out_ready  input  1  ALU consumes op_a/op_b this cycle
- op_a  output  WIDTH  registered operand A
- op_b  output  WIDTH  registered operand B

## Operation
- Operand A: rs_data if fwd_sel_a = 0, else fwd_data slice (fwd_sel_a − 1).
- Operand B: if alu_src = 1, {(WIDTH−IMM_WIDTH){imm[IMM_WIDTH−1]}, imm}; fwd_sel_b is ignored. If alu_src = 0, same rule as A, using rt_data and fwd_sel_b.
- Out-of-range select (fwd_sel > NUM_FWD) selects the register data (rs_data / rt_data).
- Accept = in_valid && in_ready. Take = out_valid && out_ready.
- Storage: output register (OUT) plus one skid register (SKID). State machine:
  - EMPTY: out_valid=0, in_ready=1. Accept → OUT loaded, go to FULL.
  - FULL: out_valid=1, in_ready=1.
    - Accept && take → OUT reloaded, stay FULL.
    - Accept && !take → new pair into SKID, go to SKID_FULL.
    - !accept && take → EMPTY.
    - Otherwise hold.
  - SKID_FULL: out_valid=1, in_ready=0. Take → SKID moves to OUT, go to FULL. Otherwise hold.
- in_ready is a decode of the state register only; it has no combinational path from out_ready.
- Priority: reset > flush > normal operation.
- Flush: state → EMPTY. A request presented in the same cycle is not accepted, and a take in that cycle is still counted by the ALU. op_a/op_b keep their last values; only out_valid qualifies them.
- Ordering is strict FIFO. No pair is lost or duplicated under any out_ready pattern.

## Timing
- Reset values, after the first rising edge with reset=1: state EMPTY, out_valid=0, in_ready=1, op_a=0, op_b=0, SKID contents=0.
- Reset held mid-operation behaves like flush and also zeroes op_a/op_b.
- Latency: a request accepted at edge n gives out_valid=1 with its operands after edge n (one cycle).
- Throughput: one pair per cycle while out_ready=1.
- Stability: while out_valid=1 and out_ready=0, op_a/op_b do not change.
- Input data is sampled only on accept. rs_data, rt_data, imm and fwd_data may change freely otherwise.
- After out_ready is deasserted, at most one further request is accepted (into SKID). in_ready falls in the cycle after that accept.

## Test plan
- Reset: hold reset 2 cycles with in_valid=1 → out_valid=0, op_a=op_b=8'h00, in_ready=1 after release; no pair is emitted.
- Sign extension (WIDTH=8, IMM_WIDTH=4): rs_data=8'h12, imm=4'hA, alu_src=1 → next cycle op_a=8'h12, op_b=8'hFA. Then imm=4'h5 → op_b=8'h05. Setting fwd_sel_b=1 does not change op_b.
- Forwarding: rs=8'h11, rt=8'h22, fwd_data={8'hBB,8'hAA}, fwd_sel_a=1, fwd_sel_b=2, alu_src=0 → op_a=8'hAA, op_b=8'hBB. fwd_sel_a=3 → op_a=8'h11.
- Backpressure: send op_a values 8'h01, 8'h02, 8'h03 back-to-back with out_ready=0. Expect 8'h01 held, 8'h02 in SKID, in_ready=0, 8'h03 waiting at the input. Raise out_ready → 8'h01, 8'h02, 8'h03 on three consecutive cycles, no gap, no duplicate.
- Flush in SKID_FULL with in_valid=1, op_a=8'h44 → next cycle out_valid=0, in_ready=1. 8'h44 is never emitted, and the next accepted pair appears one cycle later.
- Reset mid-stream in FULL state → next cycle out_valid=0, op_a=op_b=8'h00, in_ready=1.

Source files
------------

// File: rtl/alu_operand_stage.sv
// ALU operand-select stage: forwarding muxes, ALUSrc immediate select,
// and a two-entry skid buffer toward the ALU.
module alu_operand_stage #(
   parameter int WIDTH     = 8,
   parameter int IMM_WIDTH = 4,
   parameter int NUM_FWD   = 2,
   localparam int SEL_W    =
      ($clog2(NUM_FWD + 1) > 1) ? $clog2(NUM_FWD + 1) : 1
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [WIDTH-1:0]           rs_data,
   input  logic [WIDTH-1:0]           rt_data,
   input  logic [IMM_WIDTH-1:0]       imm,
   input  logic                       alu_src,
   input  logic [SEL_W-1:0]           fwd_sel_a,
   input  logic [SEL_W-1:0]           fwd_sel_b,
   input  logic [NUM_FWD*WIDTH-1:0]   fwd_data,
   input  logic                       flush,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [WIDTH-1:0]           op_a,
   output logic [WIDTH-1:0]           op_b
);

   typedef enum logic [1:0] {
      S_EMPTY     = 2'd0,
      S_FULL      = 2'd1,
      S_SKID_FULL = 2'd2
   } state_t;

   state_t           r_state;
   logic             r_out_valid;
   logic             r_in_ready;
   logic [WIDTH-1:0] r_op_a;
   logic [WIDTH-1:0] r_op_b;
   logic [WIDTH-1:0] r_skid_a;
   logic [WIDTH-1:0] r_skid_b;

   logic [WIDTH-1:0] w_a_sel;
   logic [WIDTH-1:0] w_b_reg;
   logic [WIDTH-1:0] w_b_sel;
   logic [WIDTH-1:0] w_imm_ext;
   logic             w_accept;
   logic             w_take;

   // Selects above NUM_FWD never match and fall back to register data.
   always_comb begin
      w_a_sel = rs_data;
      w_b_reg = rt_data;
      for (int k = 1; k <= NUM_FWD; k++) begin
         if (fwd_sel_a == SEL_W'(k))
            w_a_sel = fwd_data[(k-1)*WIDTH +: WIDTH];
         if (fwd_sel_b == SEL_W'(k))
            w_b_reg = fwd_data[(k-1)*WIDTH +: WIDTH];
      end
   end

   assign w_imm_ext = WIDTH'($signed(imm));
   assign w_b_sel   = alu_src ? w_imm_ext : w_b_reg;

   assign w_accept  = in_valid && r_in_ready;
   assign w_take    = r_out_valid && out_ready;

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign op_a      = r_op_a;
   assign op_b      = r_op_b;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= S_EMPTY;
         r_out_valid <= 1'b0;
         r_in_ready  <= 1'b1;
         r_op_a      <= '0;
         r_op_b      <= '0;
         r_skid_a    <= '0;
         r_skid_b    <= '0;
      end else if (flush) begin
         r_state     <= S_EMPTY;
         r_out_valid <= 1'b0;
         r_in_ready  <= 1'b1;
      end else begin
         unique case (r_state)
            S_EMPTY: begin
               if (w_accept) begin
                  r_op_a      <= w_a_sel;
                  r_op_b      <= w_b_sel;
                  r_out_valid <= 1'b1;
                  r_state     <= S_FULL;
               end
            end
            S_FULL: begin
               if (w_accept && w_take) begin
                  r_op_a <= w_a_sel;
                  r_op_b <= w_b_sel;
               end else if (w_accept) begin
                  r_skid_a   <= w_a_sel;
                  r_skid_b   <= w_b_sel;
                  r_in_ready <= 1'b0;
                  r_state    <= S_SKID_FULL;
               end else if (w_take) begin
                  r_out_valid <= 1'b0;
                  r_state     <= S_EMPTY;
               end
            end
            S_SKID_FULL: begin
               if (w_take) begin
                  r_op_a     <= r_skid_a;
                  r_op_b     <= r_skid_b;
                  r_in_ready <= 1'b1;
                  r_state    <= S_FULL;
               end
            end
            default: begin
               r_out_valid <= 1'b0;
               r_in_ready  <= 1'b1;
               r_state     <= S_EMPTY;
            end
         endcase
      end
   end

endmodule
